// File: rtl/median_pkg.sv
// Shared definitions for the three-sample median filter.
package median_pkg;

    // Default sample/result width.
    localparam int unsigned DATA_W_DEF = 8;

    // Sort sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        S1   = 2'd1,
        S2   = 2'd2,
        S3   = 2'd3
    } state_t;

endpackage

// File: rtl/median3_filter_cmp_swap.sv
// Combinational compare-swap cell: orders (a, b) into (lo, hi), unsigned.
module cmp_swap
    import median_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] hi
);

    logic swap_c;

    // Swap only on strictly greater so equal operands pass straight through.
    always_comb begin
        swap_c = (a > b);
        lo     = swap_c ? b : a;
        hi     = swap_c ? a : b;
    end

endmodule

// File: rtl/median3_filter.sv
// Three-sample median filter: capture on en_i, three sequential compare-swap
// steps, median presented on median_o with a one-cycle done_o pulse.
module median3_filter
    import median_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic [DATA_W-1:0] d1_i,
    input  logic [DATA_W-1:0] d2_i,
    input  logic [DATA_W-1:0] d3_i,
    output logic              done_o,
    output logic [DATA_W-1:0] median_o
);

    state_t state;
    state_t state_next;

    logic [DATA_W-1:0] r0;
    logic [DATA_W-1:0] r1;
    logic [DATA_W-1:0] r2;

    logic [DATA_W-1:0] lo01;
    logic [DATA_W-1:0] hi01;
    logic [DATA_W-1:0] lo12;
    logic [DATA_W-1:0] hi12;

    // (r0,r1) cell: S1 ordering step; its hi output is max(r0,r1) in S3.
    cmp_swap #(.DATA_W(DATA_W)) u_cs01 (
        .a  (r0),
        .b  (r1),
        .lo (lo01),
        .hi (hi01)
    );

    // (r1,r2) cell: S2 step pushes the maximum into r2.
    cmp_swap #(.DATA_W(DATA_W)) u_cs12 (
        .a  (r1),
        .b  (r2),
        .lo (lo12),
        .hi (hi12)
    );

    // Next-state logic; the sequence cannot be interrupted once started.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (en_i) state_next = S1;
            S1:      state_next = S2;
            S2:      state_next = S3;
            S3:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Sample registers and registered outputs; done_o defaults low each edge.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r0       <= '0;
            r1       <= '0;
            r2       <= '0;
            done_o   <= 1'b0;
            median_o <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (en_i) begin
                        r0 <= d1_i;
                        r1 <= d2_i;
                        r2 <= d3_i;
                    end
                end
                S1: begin
                    r0 <= lo01;
                    r1 <= hi01;
                end
                S2: begin
                    r1 <= lo12;
                    r2 <= hi12;
                end
                S3: begin
                    median_o <= hi01;
                    done_o   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_median3_filter.sv
// Scoreboard bench for median3_filter: stimulus pushes expected results,
// a negedge monitor pops and checks them against done_o/median_o.
module tb_median3_filter;

    localparam int unsigned W = 8;

    typedef struct {
        logic [W-1:0] med;
        int unsigned  due;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         en;
    logic [W-1:0] d1;
    logic [W-1:0] d2;
    logic [W-1:0] d3;
    logic         done;
    logic [W-1:0] median;

    int unsigned  cyc;
    int unsigned  ready;
    int unsigned  n_cmp;
    int unsigned  n_err;
    logic [W-1:0] held;
    exp_t         q[$];

    median3_filter #(.DATA_W(W)) dut (
        .clk      (clk),
        .rst_n    (rst),
        .en_i     (en),
        .d1_i     (d1),
        .d2_i     (d2),
        .d3_i     (d3),
        .done_o   (done),
        .median_o (median)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: median = sum - max - min.
    function automatic logic [W-1:0] med3(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] c);
        int ia, ib, ic, mx, mn;
        ia = int'(a); ib = int'(b); ic = int'(c);
        mx = ia; if (ib > mx) mx = ib; if (ic > mx) mx = ic;
        mn = ia; if (ib < mn) mn = ib; if (ic < mn) mn = ic;
        return W'(ia + ib + ic - mx - mn);
    endfunction

    // One input cycle; the model accepts en only when the block is idle.
    task automatic drive(input logic e, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c);
        exp_t x;
        @(posedge clk);
        #1;
        en = e; d1 = a; d2 = b; d3 = c;
        if (e && (cyc + 1 >= ready)) begin
            x.med = med3(a, b, c);
            x.due = cyc + 1 + 3;
            q.push_back(x);
            ready = cyc + 1 + 4;
        end
    endtask

    task automatic idle_rand();
        drive(1'b0, W'($urandom), W'($urandom), W'($urandom));
    endtask

    // Wait for the block to be free, then capture exactly one triple.
    task automatic capture(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
        while (cyc + 2 < ready) idle_rand();
        drive(1'b1, a, b, c);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        en = 1'b0;
        rst = 1'b1;
        q.delete();
        held = '0;
        ready = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: every cycle, done must match the scoreboard head and median must hold.
    initial begin
        forever begin
            @(negedge clk);
            if (q.size() != 0 && q[0].due == cyc) begin
                n_cmp++;
                if (done !== 1'b1 || median !== q[0].med) begin
                    n_err++;
                    $display("FAIL result @cyc %0d: done=%b median=%0d, required done=1 median=%0d",
                             cyc, done, median, q[0].med);
                end
                held = q[0].med;
                void'(q.pop_front());
            end else begin
                n_cmp++;
                if (done !== 1'b0 || median !== held) begin
                    n_err++;
                    $display("FAIL hold @cyc %0d: done=%b median=%0d, required done=0 median=%0d",
                             cyc, done, median, held);
                end
            end
        end
    end

    initial begin
        cyc = 0; ready = 0; n_cmp = 0; n_err = 0; held = '0;
        rst = 1'b1; en = 1'b0; d1 = '0; d2 = '0; d3 = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) drive(1'b0, '0, '0, '0);

        // Basic capture, then changing inputs with en low.
        capture(8'd1, 8'd2, 8'd3);
        drive(1'b0, 8'd4, 8'd5, 8'd6);
        drive(1'b0, 8'd7, 8'd8, 8'd9);
        repeat (4) idle_rand();

        // Orderings and ties.
        capture(8'd3, 8'd1, 8'd2);
        capture(8'd2, 8'd3, 8'd1);
        capture(8'd9, 8'd200, 8'd7);
        capture(8'd255, 8'd0, 8'd128);
        capture(8'd5, 8'd5, 8'd1);
        capture(8'd0, 8'd0, 8'd0);
        capture(8'd255, 8'd255, 8'd255);
        capture(8'd7, 8'd7, 8'd9);

        // Busy ignore: en pulsed during S1 must not start a new sort.
        capture(8'd10, 8'd30, 8'd20);
        drive(1'b1, 8'd99, 8'd99, 8'd99);
        repeat (6) idle_rand();

        // Continuous en: captures every 4 cycles.
        repeat (12) drive(1'b1, W'($urandom), W'($urandom), W'($urandom));
        repeat (4) idle_rand();

        // Reset in S2 discards the in-flight result.
        capture(8'd1, 8'd2, 8'd3);
        idle_rand();
        pulse_reset();
        repeat (5) idle_rand();
        capture(8'd4, 8'd6, 8'd5);
        repeat (5) idle_rand();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), W'($urandom), W'($urandom), W'($urandom));
        end
        repeat (6) idle_rand();

        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d results outstanding, required 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/median3_filter.md
# median3_filter

Three-sample median filter for the 8-bit pixel/sample datapath. A one-cycle `en_i` strobe captures three unsigned samples. The block sorts them with a sequential three-step compare-swap network and presents the median on `median_o` with a one-cycle `done_o` pulse. It sits between the sample-window builder and downstream consumers that need impulse-noise-free data.

## Interface
- `DATA_W`, default 8: width of each sample and of the result (unsigned).
- `clk`  input  1  single clock; all state changes occur on its rising edge.
- `rst_n`  input  1  asynchronous, active-high reset. The codebase port name is kept; asserting it high clears all state immediately.
- `en_i`  input  1  start strobe; sampled only in IDLE.
- `d1_i`  input  DATA_W  sample 1.
- `d2_i`  input  DATA_W  sample 2.
- `d3_i`  input  DATA_W  sample 3.
- `done_o`  output  1  one-cycle pulse: `median_o` holds a new result.
- `median_o`  output  DATA_W  median of the last captured triple; held until the next result.

## Operation
- FSM states: IDLE, S1, S2, S3. Reset state is IDLE.
- IDLE: if `en_i`=1 at a rising edge, load r0←`d1_i`, r1←`d2_i`, r2←`d3_i` and go to S1. Otherwise stay in IDLE and leave the data registers unchanged.
- S1: compare-swap (r0,r1), so r0 ends as the smaller; go to S2.
- S2: compare-swap (r1,r2), so r2 ends as the maximum; go to S3.
- S3: `median_o` ← max(r0,r1); `done_o` ← 1; go to IDLE.
- Every other edge drives `done_o` ← 0, so `done_o` is never high for two consecutive cycles.
- Compare is unsigned. A swap happens only on strictly greater; equal values are not swapped, and the result equals that value.
- `en_i` and the data inputs are ignored in S1–S3. The block is non-preemptible.
- Inputs need only be valid at the capture edge. Later changes to `d*_i` do not affect the result.

## Timing
- Reset values: `done_o`=0, `median_o`=0, r0..r2=0, state=IDLE. These take effect asynchronously on `rst_n`=1 and hold while it is high.
- Capture at edge E0. `median_o` and `done_o` update at E3, and `done_o` is high from E3 to E4. Latency is 3 cycles from capture to result.
- The earliest next capture is E4, when the FSM is back in IDLE. Maximum throughput is one result per 4 cycles.
- If reset asserts mid-operation (S1–S3), the in-flight result is discarded, no `done_o` pulse is produced, and `median_o` returns to 0.
- If `en_i` is held high continuously, a new capture occurs every 4 cycles.
- Reset deassertion is synchronized externally. The first capture is allowed at the first edge after release.

## Structure
- Shared package `median_pkg`: the `DATA_W` default and a state enum typedef (IDLE, S1, S2, S3).
- One natural sub-module, `cmp_swap`: combinational; inputs a, b; outputs lo, hi; swaps only when a > b. Instantiate it for the S1 and S2 steps, and reuse its hi output for the S3 max.
- The remainder is a single sequential process for the FSM and registers, plus output registers.

## Test plan
- Reset: hold `rst_n`=1 for 1 cycle → `done_o`=0, `median_o`=0. After release with `en_i`=0 for 10 cycles → no `done_o` pulse.
- Basic capture: `en_i`=1 for one cycle with d=(1,2,3); then `en_i`=0 while inputs change to (4,5,6) and (7,8,9) → exactly one `done_o` pulse 3 cycles after capture, `median_o`=2 and held afterwards, with no further pulses.
- Ordering permutations: (3,1,2), (2,3,1), (9,200,7), (255,0,128) → medians 2, 2, 9, 128.
- Ties: (5,5,1) → 5; (0,0,0) → 0; (255,255,255) → 255.
- Busy ignore: capture (10,30,20), then pulse `en_i` in S1 with (99,99,99) → single result 20, and the next `done_o` only after a fresh IDLE capture.
- Reset mid-operation: capture (1,2,3), assert `rst_n` in S2 → no `done_o`, `median_o`=0. A later capture of (4,6,5) → 5.
